bc_ctrl_arbiter: RTL and testbench
==================================

Name: bc_ctrl_arbiter

Overview:
- Shares the single 16-bit ctrl-side write channel of bc_buffer (ctrl_in_valid/ctrl_in_rdy/ctrl_in_data) between NUM_REQ upstream requesters.
- Arbitration is round-robin and burst-locked. A grant lasts until the requester flags its last word, or until MAX_BURST words have been accepted.
- Sits directly upstream of bc_buffer. Its out_* port connects to bc_buffer ctrl_in_*.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 16, word width; matches the bc_buffer data width.
- MAX_BURST, 8, maximum words per grant (1..255).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester last-word-of-burst flag; qualified by req_valid.
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_rdy  out  NUM_REQ  per-requester ready.
- out_valid  out  1  to bc_buffer ctrl_in_valid.
- out_data  out  DATA_W  to bc_buffer ctrl_in_data.
- out_rdy  in  1  from bc_buffer ctrl_in_rdy.
- gnt_id  out  3  index of the current grantee; valid only while busy=1.
- busy  out  1  high while in the GRANT state.
- trunc  out  1  one-cycle pulse when a burst is ended by MAX_BURST rather than by req_last.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, rr_ptr=0, word_cnt=0, gnt_id=0.
  - busy=0, trunc=0, out_valid=0, req_rdy=0.
  - out_data is don't-care, but must not be X during a handshake.
  - Reset asserted mid-burst aborts the burst at that edge. No word is accepted in the reset cycle.
- Handshake:
  - A word transfers on a cycle where out_valid && out_rdy.
  - In GRANT, the path is combinational passthrough with zero latency:
    - out_valid = req_valid[gnt_id]
    - out_data = req_data[gnt_id]
    - req_rdy[gnt_id] = out_rdy
  - All other req_rdy bits are 0.
  - out_valid never depends on out_rdy. Requesters must hold data stable while valid && !rdy.
- State IDLE:
  - out_valid=0, req_rdy=0.
  - If any req_valid is set, choose the first set index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register that index into gnt_id, clear word_cnt, and go to GRANT next cycle.
  - Arbitration latency is 1 cycle from req_valid to out_valid.
- State GRANT:
  - On each transfer, word_cnt increments.
  - The burst ends on a transfer where req_last[gnt_id]=1, or where word_cnt==MAX_BURST-1.
  - At burst end:
    - Go to IDLE.
    - rr_ptr = (gnt_id+1) mod NUM_REQ.
    - trunc pulses on the next cycle if the end came from the count limit and req_last was 0.
  - If both end conditions hold on the same transfer, trunc=0.
  - If req_valid[gnt_id] drops mid-burst, stay in GRANT. The grant is held; there is no timeout.
  - If out_rdy=0, word_cnt holds and the state holds.
- Back-to-back grants:
  - There is exactly one IDLE bubble cycle between bursts, even if the same requester is the only one requesting.
  - Maximum sustained throughput is MAX_BURST/(MAX_BURST+1).
- Fairness: once a requester's burst ends, every other requester that is continuously requesting is granted before it again.
- Requesters not granted see req_rdy=0. Their valid/data are ignored and never reach out_data.
- gnt_id width is 3 bits. Values >= NUM_REQ never occur.

Test Plan:
- Single requester:
  - Stimulus: after reset release, req0 sends 4 words 0x0010..0x0013 with last on 0x0013; out_rdy=1.
  - Response: out_valid rises 1 cycle after req_valid; 4 consecutive transfers in order; busy falls the cycle after the last transfer; trunc=0.
- Round-robin:
  - Stimulus: req0, req1, req2 all continuously valid, each burst 2 words with last; out_rdy=1.
  - Response: grant order 0,1,2,0,1,2; each burst is separated by exactly 1 idle cycle; no data from a non-granted requester appears on out_data.
- Truncation:
  - Stimulus: req1 streams 12 words 0x0100..0x010B with no last; MAX_BURST=8; req0 also valid.
  - Response: words 0x0100..0x0107 pass; trunc pulses once; the next grant is to req2 if valid, else req0; the 0x0108 word stays held on req1.
- Backpressure:
  - Stimulus: out_rdy toggles 1,0,0,1,... during a 5-word burst from req2.
  - Response: every word is transferred exactly once; req_rdy[2] mirrors out_rdy; word_cnt holds during stalls; the burst still ends on last.
- Reset mid-burst:
  - Stimulus: drive rst=0 for 1 cycle after the 3rd word of a req0 burst.
  - Response: next cycle busy=0, out_valid=0, rr_ptr=0; after release, req0 is re-granted first when all requesters are valid.
- Same-cycle end conditions:
  - Stimulus: the 8th word carries last=1 (MAX_BURST=8).
  - Response: the burst ends; trunc stays 0.

Source files
------------

// File: rtl/bc_ctrl_arbiter.sv
// Round-robin, burst-locked arbiter sharing the bc_buffer ctrl-side write channel
// between NUM_REQ requesters, with a zero-latency passthrough while a grant is held.
module bc_ctrl_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_rdy,
    output logic [2:0]                gnt_id,
    output logic                      busy,
    output logic                      trunc
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] NREQ    = 4'(NUM_REQ);
    localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);
    localparam logic [7:0] CNT_LIM = 8'(MAX_BURST - 1);

    state_t            state, state_nxt;
    logic [2:0]        rr_ptr, rr_nxt, gnt_nxt;
    logic [7:0]        word_cnt, cnt_nxt;
    logic              trunc_nxt;
    logic [7:0]        valid8, last8, rdy8;
    logic [DATA_W-1:0] lane [8];
    logic              active, xfer, pick_found;
    logic [2:0]        pick;
    logic [3:0]        idx;

    // Requester lanes are widened to 8 so the 3-bit grant index always selects in range.
    assign valid8 = 8'(req_valid);
    assign last8  = 8'(req_last);

    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < NUM_REQ) begin : g_used
            assign lane[g] = req_data[g*DATA_W +: DATA_W];
        end else begin : g_unused
            assign lane[g] = '0;
        end
    end

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_found && valid8[idx[2:0]]) begin
                pick       = idx[2:0];
                pick_found = 1'b1;
            end
        end
    end

    // The passthrough is gated by rst so no word can be accepted during a reset cycle.
    always_comb begin
        active    = (state == GRANT) && rst;
        xfer      = active && valid8[gnt_id] && out_rdy;
        state_nxt = state;
        gnt_nxt   = gnt_id;
        rr_nxt    = rr_ptr;
        cnt_nxt   = word_cnt;
        trunc_nxt = 1'b0;
        rdy8      = '0;
        out_valid = active && valid8[gnt_id];
        out_data  = active ? lane[gnt_id] : '0;
        if (active) begin
            rdy8[gnt_id] = out_rdy;
        end
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nxt   = pick;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_nxt = word_cnt + 8'd1;
                    if (last8[gnt_id] || (word_cnt == CNT_LIM)) begin
                        state_nxt = IDLE;
                        rr_nxt    = (gnt_id == LAST_ID) ? 3'd0 : gnt_id + 3'd1;
                        trunc_nxt = !last8[gnt_id];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_rdy = rdy8[NUM_REQ-1:0];
    assign busy    = (state == GRANT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            word_cnt <= '0;
            gnt_id   <= '0;
            trunc    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            word_cnt <= cnt_nxt;
            gnt_id   <= gnt_nxt;
            trunc    <= trunc_nxt;
        end
    end

endmodule

// File: tb/tb_bc_ctrl_arbiter.sv
// Bench for bc_ctrl_arbiter: per-requester word queues drive the inputs and a
// grant-owner model predicts the outputs every cycle, plus directed literal checks.
module tb_bc_ctrl_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_rdy;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_rdy = 1'b1;
    logic [2:0]                gnt_id;
    logic                      busy;
    logic                      trunc;

    always #5 clk = ~clk;

    bc_ctrl_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_rdy(req_rdy), .out_valid(out_valid),
        .out_data(out_data), .out_rdy(out_rdy), .gnt_id(gnt_id), .busy(busy),
        .trunc(trunc)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_pct = 100;
    int rdy_mode = 0;

    // Each queue entry is {last, data}; the head is what the requester presents.
    logic [16:0]        stream [NUM_REQ][$];
    logic [NUM_REQ-1:0] cur_valid = '0;
    logic [NUM_REQ-1:0] hs = '0;

    int  owner = -1;
    int  ptr = 0;
    int  cnt = 0;
    bit  trunc_pend = 1'b0;
    bit  model_live = 1'b0;
    int  trunc_cnt = 0;
    int  gnt_log[$];
    int  gnt_cyc[$];
    logic [15:0] xfer_log[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic               exp_ov;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [16:0]        head;
        logic [15:0]        exp_data;
        cyc++;
        exp_ov   = 1'b0;
        exp_rdy  = '0;
        exp_data = '0;
        if (model_live) begin
            if (owner >= 0 && rst) begin
                exp_ov = req_valid[owner];
                exp_rdy[owner] = out_rdy;
            end
            check_output("busy", 32'(busy), 32'(owner >= 0));
            check_output("out_valid", 32'(out_valid), 32'(exp_ov));
            check_output("req_rdy", 32'(req_rdy), 32'(exp_rdy));
            check_output("trunc", 32'(trunc), 32'(trunc_pend));
            if (owner >= 0) check_output("gnt_id", 32'(gnt_id), 32'(owner));
            if (exp_ov) begin
                head = stream[owner][0];
                exp_data = head[15:0];
                check_output("out_data", 32'(out_data), 32'(exp_data));
            end
            hs = req_valid & exp_rdy;
        end else begin
            hs = '0;
        end

        if (!rst) begin
            owner = -1; ptr = 0; cnt = 0; trunc_pend = 1'b0; model_live = 1'b1;
        end else if (model_live) begin
            trunc_pend = 1'b0;
            if (owner < 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (owner < 0 && req_valid[(ptr + k) % NUM_REQ]) begin
                        owner = (ptr + k) % NUM_REQ;
                        cnt = 0;
                        gnt_log.push_back(owner);
                        gnt_cyc.push_back(cyc);
                    end
                end
            end else if (exp_ov && out_rdy) begin
                xfer_log.push_back(exp_data);
                cnt++;
                if (req_last[owner] || cnt == MAX_BURST) begin
                    ptr = (owner + 1) % NUM_REQ;
                    trunc_pend = !req_last[owner];
                    if (trunc_pend) trunc_cnt++;
                    owner = -1;
                end
            end
        end
    end

    task automatic drive_reqs();
        logic [16:0] head;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cur_valid[i] && hs[i]) begin
                stream[i].delete(0);
                cur_valid[i] = 1'b0;
            end
            if (!cur_valid[i] && stream[i].size() > 0 && int'($urandom_range(99)) < valid_pct)
                cur_valid[i] = 1'b1;
            req_valid[i] = cur_valid[i];
            if (cur_valid[i]) begin
                head = stream[i][0];
                req_data[i*DATA_W +: DATA_W] = head[15:0];
                req_last[i] = head[16];
            end else begin
                req_data[i*DATA_W +: DATA_W] = 16'($urandom);
                req_last[i] = 1'($urandom_range(1));
            end
        end
        case (rdy_mode)
            1:       out_rdy = (cyc % 3 == 0);
            2:       out_rdy = 1'($urandom_range(1));
            default: out_rdy = 1'b1;
        endcase
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        drive_reqs();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_burst(input int r, input logic [15:0] base, input int len, input bit with_last);
        for (int k = 0; k < len; k++)
            stream[r].push_back({with_last && (k == len - 1), base + 16'(k)});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) stream[i].delete();
        cur_valid = '0;
        repeat (2) apply_stimulus();
        rst = 1'b1;
        sample();
        check_output("rst_gnt_id", 32'(gnt_id), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_req_rdy", 32'(req_rdy), 32'd0);
        gnt_log.delete(); gnt_cyc.delete(); xfer_log.delete(); trunc_cnt = 0;
    endtask

    function automatic int log_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    function automatic int xfer_at(input int i);
        return (i < xfer_log.size()) ? int'(xfer_log[i]) : -1;
    endfunction

    initial begin
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
        bit drained;

        // Single requester: one-cycle arbitration latency then four back-to-back words.
        do_reset();
        push_burst(0, 16'h0010, 4, 1'b1);
        apply_stimulus(); sample();
        check_output("p1_latency", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(); sample();
            check_output("p1_valid", 32'(out_valid), 32'd1);
            check_output("p1_data", 32'(out_data), 32'h10 + 32'(k));
        end
        apply_stimulus(); sample();
        check_output("p1_busy_fall", 32'(busy), 32'd0);
        check_output("p1_trunc_cnt", 32'(trunc_cnt), 32'd0);

        // Round robin with two-word bursts.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            for (int b = 0; b < 2; b++)
                push_burst(i, 16'h0200 + 16'(i*16 + b*2), 2, 1'b1);
        repeat (25) apply_stimulus();
        check_output("p2_grants", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) check_output("p2_order", 32'(log_at(i)), 32'(exp_order[i]));
        if (gnt_cyc.size() == 6) check_output("p2_spacing", 32'(gnt_cyc[5] - gnt_cyc[0]), 32'd15);

        // Truncation at MAX_BURST while req0 waits.
        do_reset();
        push_burst(1, 16'h0100, 12, 1'b0);
        repeat (2) apply_stimulus();
        push_burst(0, 16'h0300, 2, 1'b1);
        repeat (30) apply_stimulus();
        check_output("p3_trunc_cnt", 32'(trunc_cnt), 32'd1);
        check_output("p3_first_gnt", 32'(log_at(0)), 32'd1);
        check_output("p3_next_gnt", 32'(log_at(1)), 32'd0);
        check_output("p3_word7", 32'(xfer_at(7)), 32'h0107);
        check_output("p3_word8", 32'(xfer_at(8)), 32'h0300);
        check_output("p3_total", 32'(xfer_log.size()), 32'd14);

        // Backpressure on a five-word burst from req2.
        do_reset();
        rdy_mode = 1;
        push_burst(2, 16'h0400, 5, 1'b1);
        repeat (40) apply_stimulus();
        rdy_mode = 0;
        check_output("p4_total", 32'(xfer_log.size()), 32'd5);
        check_output("p4_last", 32'(xfer_at(4)), 32'h0404);
        check_output("p4_grants", 32'(gnt_log.size()), 32'd1);

        // Reset in the middle of a req0 burst.
        do_reset();
        push_burst(0, 16'h0500, 6, 1'b1);
        push_burst(1, 16'h0510, 2, 1'b1);
        push_burst(2, 16'h0520, 2, 1'b1);
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(); sample();
            if (xfer_log.size() >= 3) break;
        end
        check_output("p5_three_words", 32'(xfer_log.size()), 32'd3);
        apply_stimulus();
        rst = 1'b0;
        sample();
        check_output("p5_rst_cycle_valid", 32'(out_valid), 32'd0);
        apply_stimulus();
        rst = 1'b1;
        sample();
        check_output("p5_busy_after", 32'(busy), 32'd0);
        check_output("p5_valid_after", 32'(out_valid), 32'd0);
        repeat (10) apply_stimulus();
        check_output("p5_regrant", 32'(log_at(1)), 32'd0);
        check_output("p5_resent", 32'(xfer_at(3)), 32'h0503);

        // Last flag on the MAX_BURST-th word: no truncation.
        do_reset();
        push_burst(0, 16'h0600, 8, 1'b1);
        push_burst(1, 16'h0610, 2, 1'b1);
        repeat (20) apply_stimulus();
        check_output("p6_trunc_cnt", 32'(trunc_cnt), 32'd0);
        check_output("p6_next_gnt", 32'(log_at(1)), 32'd1);
        check_output("p6_total", 32'(xfer_log.size()), 32'd10);

        // Randomized traffic, gaps and backpressure.
        for (int iter = 0; iter < 4; iter++) begin
            do_reset();
            valid_pct = 50 + 10 * iter;
            rdy_mode = 2;
            for (int i = 0; i < NUM_REQ; i++) begin
                int nb = int'($urandom_range(4, 1));
                for (int b = 0; b < nb; b++)
                    push_burst(i, 16'(i << 12) + 16'(b << 5), int'($urandom_range(14, 1)), 1'b1);
            end
            drained = 1'b0;
            for (int c = 0; c < 2000 && !drained; c++) begin
                apply_stimulus();
                drained = 1'b1;
                for (int i = 0; i < NUM_REQ; i++)
                    if (stream[i].size() != 0 || cur_valid[i]) drained = 1'b0;
            end
            for (int i = 0; i < NUM_REQ; i++)
                check_output("rand_drain", 32'(stream[i].size()), 32'd0);
        end
        valid_pct = 100;
        rdy_mode = 0;
        repeat (3) apply_stimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
